// File: rtl/mux16_bus_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit output bus between N_REQ requesters.
// Each transfer is latched, handed over with valid/ready, then acknowledged by a one-cycle done pulse.

module mux16_bus_arbiter_lane #(
  parameter int WIDTH = 16
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  assign q_o = en_i ? d_i : '0;
endmodule

module mux16_bus_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [N_REQ-1:0]       grant,
  output logic [1:0]             sel,
  output logic [N_REQ-1:0]       done,
  output logic [15:0]            xfer_count
);
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    valid_q, valid_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [N_REQ-1:0]        done_q, done_d;
  logic [SEL_W-1:0]        last_q, last_d;
  logic [15:0]             xfer_cnt_q, xfer_cnt_d;

  logic [SEL_W-1:0]        win;
  logic [SEL_W-1:0]        cand;
  logic                    found;
  logic [N_REQ-1:0][WIDTH-1:0] lane_in, lane_out;
  logic [WIDTH-1:0]        win_data;

  assign lane_in = data_in;

  // Search starts one past the previous winner, so the last owner ends up lowest priority.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_q + SEL_W'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // AND-OR mux tree: each lane gates its word with the decoded winner.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    mux16_bus_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
      .en_i (win == SEL_W'(i)),
      .d_i  (lane_in[i]),
      .q_o  (lane_out[i])
    );
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) win_data = win_data | lane_out[i];
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    done_d     = '0;
    last_d     = last_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          sel_d        = win;
          data_d       = win_data;
          valid_d      = 1'b1;
        end
      end
      BUSY: begin
        // Owner dropping req here is ignored; the latched word still completes.
        if (out_ready) begin
          state_d    = DONE;
          valid_d    = 1'b0;
          grant_d    = '0;
          done_d     = grant_q;
          last_d     = sel_q;
          xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      sel_q      <= '0;
      done_q     <= '0;
      last_q     <= SEL_W'(N_REQ - 1);
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      last_q     <= last_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign grant      = grant_q;
  assign sel        = sel_q;
  assign done       = done_q;
  assign xfer_count = xfer_cnt_q;
endmodule
